// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader assembling a byte stream into 32-bit instruction-memory writes
// Frame: LEN byte, 4*LEN data bytes (little-endian words), XOR checksum byte.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       wd_q, wd_d;
  logic              err_q, err_d;
  logic              xfer;

  // Handshake outputs come from the registered state only, so rx_valid/start never reach them.
  assign rx_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign we       = (state_q == S_WRITE);
  assign busy     = rx_ready || we;
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign wa       = addr_q;
  assign wd       = wd_q;
  assign xfer     = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN;
          err_d   = 1'b0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          cnt_d   = rx_data;
          csum_d  = rx_data;
          addr_d  = '0;
          idx_d   = '0;
          state_d = (rx_data == 8'd0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          wd_d[{idx_q, 3'b000} +: 8] = rx_data;
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) begin
          err_d   = (rx_data != csum_q);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
